// File: rtl/spi_matrix_rx_framer.sv
// spi_matrix_rx_framer: SPI mode-0 receiver that frames a header plus data words into A/B matrix buffer writes
module spi_matrix_rx_framer #(
  parameter int MAX_M = 784,
  parameter int MAX_K = 288,
  parameter int MAX_N = 64,
  localparam int A_WORDS = MAX_M * MAX_K,
  localparam int B_WORDS = MAX_K * MAX_N,
  localparam int ADDR_W = $clog2(A_WORDS > B_WORDS ? A_WORDS : B_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  input  logic              clr_ready,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              a_ready,
  output logic              b_ready,
  output logic              frame_err
);
  localparam logic [29:0] A_LIM = 30'(A_WORDS);
  localparam logic [29:0] B_LIM = 30'(B_WORDS);
  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_e;
  state_e state_q, state_d;
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;
  logic [31:0] shift_q, shift_d, wr_data_q, wr_data_d, word;
  logic [4:0] bit_q, bit_d;
  logic [ADDR_W-1:0] idx_q, idx_d, cnt_q, cnt_d, wr_addr_q, wr_addr_d;
  logic wr_en_q, wr_en_d, wr_sel_q, wr_sel_d, a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d, err_q, err_d;
  logic sclk_rise, cs_fall, cs_rise, active, shift_en, word_done, hdr_bad, last;
  logic hdr_ok, hdr_err, wr_fire, set_rdy;
  logic [1:0] tgt;
  logic [29:0] wcnt;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign active    = (state_q == HDR) | (state_q == DATA);
  assign shift_en  = active & sclk_rise;
  assign word      = {shift_q[30:0], mosi_q[1]};
  assign word_done = shift_en & (bit_q == 5'd31);
  assign tgt       = word[31:30];
  assign wcnt      = word[29:0];
  assign hdr_bad   = tgt[1] | (wcnt == 30'd0) | (tgt[0] ? wcnt > B_LIM : wcnt > A_LIM);
  assign last      = idx_q == cnt_q - ADDR_W'(1);
  assign hdr_ok    = (state_q == HDR) & word_done & ~cs_rise & ~hdr_bad;
  assign hdr_err   = (state_q == HDR) & word_done & ~cs_rise & hdr_bad;
  assign wr_fire   = (state_q == DATA) & word_done & ~cs_rise;
  assign set_rdy   = wr_fire & last;
  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign a_ready   = a_rdy_q;
  assign b_ready   = b_rdy_q;
  assign frame_err = err_q;
  // two-flop synchronisers plus a third stage on sclk and cs_n for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // FSM next state; a cs_n rise always returns to IDLE and outranks a coincident word
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cs_fall ? HDR : IDLE;
      HDR:     state_d = cs_rise ? IDLE : word_done ? (hdr_bad ? ERR : DATA) : HDR;
      DATA:    state_d = cs_rise ? IDLE : (word_done & last) ? DONE : DATA;
      DONE:    state_d = cs_rise ? IDLE : DONE;
      ERR:     state_d = cs_rise ? IDLE : ERR;
      default: state_d = IDLE;
    endcase
  end
  // datapath and output next-state: word assembly, header latch, write strobe and flags
  always_comb begin
    bit_d     = (state_q == IDLE && cs_fall) ? 5'd0 : shift_en ? bit_q + 5'd1 : bit_q;
    shift_d   = shift_en ? word : shift_q;
    cnt_d     = hdr_ok ? ADDR_W'(wcnt) : cnt_q;
    idx_d     = (hdr_ok || (state_q == IDLE && cs_fall)) ? '0 : wr_fire ? idx_q + ADDR_W'(1) : idx_q;
    wr_sel_d  = hdr_ok ? tgt[0] : wr_sel_q;
    wr_en_d   = wr_fire;
    wr_addr_d = wr_fire ? idx_q : wr_addr_q;
    wr_data_d = wr_fire ? word : wr_data_q;
    a_rdy_d   = (set_rdy & ~wr_sel_q) | (a_rdy_q & ~clr_ready);
    b_rdy_d   = (set_rdy & wr_sel_q) | (b_rdy_q & ~clr_ready);
    err_d     = hdr_err | (active & cs_rise);
  end
  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_sel_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      a_rdy_q   <= 1'b0;
      b_rdy_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_sel_q  <= wr_sel_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      a_rdy_q   <= a_rdy_d;
      b_rdy_q   <= b_rdy_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: doc/spi_matrix_rx_framer.md
Name: spi_matrix_rx_framer

Overview:
- Upstream front-end of the matrix-load path; it turns the raw SPI pins into word writes for the A and B operand buffers.
- Synchronises SCLK/MOSI/CS_N into the clk domain (SPI mode 0, MSB first) and assembles 32-bit words.
- Parses a one-word frame header and emits addressed single-cycle write strobes for matrix A or matrix B.
- Raises sticky per-matrix ready flags that the engine start logic consumes.

Parameters:
- MAX_M, 784, max rows of A
- MAX_K, 288, max cols of A / rows of B
- MAX_N, 64, max cols of B
- ADDR_W, derived: $clog2(max(MAX_M*MAX_K, MAX_K*MAX_N)), write address width

Ports:
- clk  in  1  system clock; must be >= 8x the sclk frequency
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock, asynchronous to clk
- mosi  in  1  SPI data in
- cs_n  in  1  SPI chip select, active low
- clr_ready  in  1  one-cycle pulse; clears a_ready and b_ready
- wr_en  out  1  one-cycle write strobe
- wr_sel  out  1  write target: 0=A, 1=B
- wr_addr  out  ADDR_W  linear element index, row-major
- wr_data  out  32  element data, IEEE-754 single-precision bits
- a_ready  out  1  sticky; A frame completed
- b_ready  out  1  sticky; B frame completed
- frame_err  out  1  one-cycle pulse on a bad or aborted frame

Behaviour:
- Reset: rst_n is asynchronous, active-low. All outputs reset to 0; FSM to IDLE; the bit counter, word counter and sync flops reset to 0, and the cs_n sync chain resets to 1.

Synchronisation:
- 2-flop synchronisers on sclk, mosi and cs_n.
- A third flop on sclk and on cs_n provides edge detection.
- Data is sampled on the synchronised sclk rising edge. mosi is delayed by the same depth as sclk.

Word assembly:
- A 32-bit shift register shifts left and inserts mosi at bit 0.
- A 5-bit bit counter counts edges; the 32nd edge completes a word, and the counter wraps to 0.

FSM:
- IDLE: on the synchronised cs_n falling edge, clear the counters and go to HDR.
- HDR: on word complete, decode the header. Bits [31:30] are the target (00=A, 01=B, 1x=invalid). Bits [29:0] are the word count W.
  - Error if the target is invalid, W==0, W>MAX_M*MAX_K for A, or W>MAX_K*MAX_N for B.
  - On error: pulse frame_err and go to ERR.
  - Otherwise: latch the target in wr_sel and W, set the word index to 0, go to DATA.
  - No write occurs for the header.
- DATA: on each word complete, in the next clk cycle:
  - wr_en=1, wr_data=word, wr_addr=index; then index increments.
  - When index reaches W-1, go to DONE.
  - On that final write's cycle, set a_ready (target A) or b_ready (target B).
- DONE: further sclk edges are ignored; no writes occur. Go to IDLE on the cs_n rising edge.
- ERR: all input is ignored. Go to IDLE on the cs_n rising edge.

Abort and edge cases:
- cs_n rising while in HDR or DATA is an abort: pulse frame_err, go to IDLE.
  - Writes already issued stand.
  - The ready flag is not set, and the partial word is discarded.
- cs_n rising in IDLE, DONE or ERR produces no error.
- wr_sel, wr_addr and wr_data hold their last values when wr_en=0.
- a_ready and b_ready are independent.
  - A second A frame re-sets a_ready (it stays 1).
  - A new frame does not clear ready flags; only clr_ready or reset does.
  - If clr_ready coincides with a ready-set in the same cycle, set wins.
- Latency: wr_en asserts exactly 1 clk after the cycle in which the 32nd synchronised rising edge of the word is detected.
- Throughput: at most one write per 32 sclk periods; no backpressure; the downstream buffer must accept every strobe.

Test Plan:
- Header 0x00000004, then 4 words 0x3F800000, 0x40000000, 0x40400000, 0x40800000 -> 4 wr_en pulses with wr_sel=0, addr 0..3 and matching data; a_ready=1 on the 4th pulse; frame_err never asserted.
- B frame with header 0x40000002, words 0xBF800000, 0x00000000, then an A frame of 1 word, then a clr_ready pulse -> wr_sel=1 at addr 0,1; both ready flags set; both cleared the cycle after clr_ready.
- Header 0x80000001 (invalid target) and header 0x00037201 (W=225793 > 225792) -> one frame_err pulse each, zero wr_en, ready flags stay 0.
- A frame with W=3 where cs_n rises after 1 word plus 17 bits -> exactly 1 write (addr 0), one frame_err pulse, a_ready=0; the next valid frame starts at addr 0.
- W=2 frame followed by 3 extra words before cs_n rises -> exactly 2 writes, no error, b_ready or a_ready set per target.
- rst_n asserted mid-DATA (after 2 of 5 words) -> outputs 0 immediately; after release, a fresh full frame is accepted correctly. Also run all of the above with the sclk:clk ratio at 1:8 and with sclk phase jitter.
